// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule constants, types and S-box lookup.
`timescale 1ns/1ps
package aes_key_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int NUM_SLOTS  = NUM_ROUNDS + 1;

  // Last round index as a 4-bit value, for comparisons against the round counter.
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  // 128-bit key, bit 0 is the MSB of byte 0 (column-major byte order).
  typedef logic [0:127] key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Round constants in the top byte of a 32-bit word; entry 0 is unused.
  localparam logic [31:0] RCON [0:NUM_ROUNDS] = '{
    32'h00000000, 32'h01000000, 32'h02000000, 32'h04000000,
    32'h08000000, 32'h10000000, 32'h20000000, 32'h40000000,
    32'h80000000, 32'h1b000000, 32'h36000000
  };

  // AES forward S-box, byte n at bits [8n +: 8].
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/round_key.sv
// One AES-128 key-expansion round: previous round key in, next round key out.
`timescale 1ns/1ps
module round_key
  import aes_key_pkg::*;
(
  input  key_t        key_i,
  input  logic [31:0] rcon_i,
  output key_t        key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_i[0:31];
  assign w1 = key_i[32:63];
  assign w2 = key_i[64:95];
  assign w3 = key_i[96:127];

  // RotWord of word 3 gives byte order 13,14,15,12.
  assign rot = {w3[23:0], w3[31:24]};
  assign t   = sub_word(rot) ^ rcon_i;

  // Each new word chains off the one just produced.
  assign n0 = t  ^ w0;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/key_expand_seq.sv
// Sequential AES-128 key expansion: one round per cycle into an 11-slot key store.
`timescale 1ns/1ps
module key_expand_seq
  import aes_key_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] key_in,
  input  logic [3:0]   rd_idx,
  output logic [0:127] rd_key,
  output logic         busy,
  output logic         done,
  output logic         keys_valid
);

  state_e      state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        kv_q, kv_d;
  key_t        slots_q [0:NUM_SLOTS-1];

  logic        we;
  logic [3:0]  widx;
  key_t        wdata;

  key_t        rk_prev, rk_next;
  logic [31:0] rk_rcon;

  // Feed the shared round unit with the previous slot and this round's Rcon.
  always_comb begin
    rk_prev = slots_q[0];
    rk_rcon = '0;
    if (rnd_q != 4'd0 && rnd_q <= LAST_RND) begin
      rk_prev = slots_q[rnd_q - 4'd1];
      rk_rcon = RCON[rnd_q];
    end
  end

  round_key u_round_key (
    .key_i  (rk_prev),
    .rcon_i (rk_rcon),
    .key_o  (rk_next)
  );

  // Next-state logic and key-store write port.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    kv_d    = kv_q;
    we      = 1'b0;
    widx    = '0;
    wdata   = key_in;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Accepting a new key invalidates the store until round 10 lands.
          state_d = ST_EXPAND;
          rnd_d   = 4'd1;
          kv_d    = 1'b0;
          we      = 1'b1;
          widx    = 4'd0;
          wdata   = key_in;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        // start is deliberately ignored here so a running sequence is never disturbed.
        we    = 1'b1;
        widx  = rnd_q;
        wdata = rk_next;
        if (rnd_q == LAST_RND) begin
          state_d = ST_DONE;
          rnd_d   = 4'd0;
          kv_d    = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rnd_d   = 4'd0;
        kv_d    = 1'b0;
      end
    endcase
  end

  // State, round counter, valid flag and key store registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= 4'd0;
      kv_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      kv_q    <= kv_d;
      if (we) slots_q[widx] <= wdata;
    end
  end

  // Read port reflects the store in every state; out-of-range indices read zero.
  always_comb begin
    rd_key = '0;
    if (rd_idx <= LAST_RND) rd_key = slots_q[rd_idx];
  end

  assign busy       = (state_q == ST_EXPAND);
  assign done       = (state_q == ST_DONE);
  assign keys_valid = kv_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// Self-checking bench for key_expand_seq against an arithmetic AES key-schedule model.
`timescale 1ns/1ps
module tb_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [127:0] key_in, rd_key;
  logic [3:0]   rd_idx;
  logic         busy, done, keys_valid;

  always #5 clk = ~clk;

  key_expand_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]   sbm  [256];
  logic [127:0] gold [11];

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      sbm[v] = s ^ 8'h63;
    end
  endtask

  // Word-indexed FIPS-197 recurrence producing all eleven round keys.
  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) gold[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read every index; zeros=1 expects a cleared store.
  task automatic sweep(input string tag, input bit zeros);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #0.5;
      chk($sformatf("%s[%0d]", tag, i), rd_key, (i <= 10 && !zeros) ? gold[i] : 128'h0);
    end
    rd_idx = 4'd0;
  endtask

  // Single-cycle start, then wait (bounded) for done; reports latency and busy cycles.
  task automatic run(input string tag, input logic [127:0] k, output int lat, output int bcnt);
    start = 1'b1;
    key_in = k;
    tick();
    start = 1'b0;
    rd_idx = 4'd0;
    #0.5;
    chk({tag, "_slot0"}, rd_key, k);
    chk({tag, "_kv_low"}, 128'(keys_valid), 128'd0);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 30) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    chk({tag, "_kv_at_done"}, 128'(keys_valid), 128'd1);
  endtask

  initial begin
    int lat, bcnt;
    bit saw_done;
    logic [127:0] ka, kb;

    rst_n = 1'b0; start = 1'b0; key_in = '0; rd_idx = '0;
    build_sbox();
    repeat (3) tick();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_kv", 128'(keys_valid), 128'd0);
    sweep("rst_slot", 1'b1);
    rst_n = 1'b1;
    tick();

    // FIPS-197 example key.
    model(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, lat, bcnt);
    chk("fips_latency", 128'(lat), 128'd10);
    chk("fips_busy_cycles", 128'(bcnt), 128'd10);
    rd_idx = 4'd1; #0.5;
    chk("fips_slot1_const", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_idx = 4'd10; #0.5;
    chk("fips_slot10_const", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep("fips_slot", 1'b0);
    tick();
    chk("after_done_done", 128'(done), 128'd0);
    chk("after_done_busy", 128'(busy), 128'd0);
    chk("after_done_kv", 128'(keys_valid), 128'd1);

    // Ascending-byte key.
    model(128'h000102030405060708090a0b0c0d0e0f);
    run("seq", 128'h000102030405060708090a0b0c0d0e0f, lat, bcnt);
    chk("seq_latency", 128'(lat), 128'd10);
    chk("seq_busy_cycles", 128'(bcnt), 128'd10);
    rd_idx = 4'd10; #0.5;
    chk("seq_slot10_const", rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    sweep("seq_slot", 1'b0);

    // start during EXPAND with another key must be ignored.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    model(ka);
    start = 1'b1; key_in = ka;
    tick();
    start = 1'b0; lat = 0;
    repeat (3) begin tick(); lat++; end
    start = 1'b1; key_in = kb;
    tick(); lat++;
    start = 1'b0; key_in = '0;
    while (!done && lat < 30) begin tick(); lat++; end
    chk("ign_latency", 128'(lat), 128'd10);
    sweep("ign_slot", 1'b0);

    // Reset mid-expansion aborts and clears; start under reset is ignored.
    start = 1'b1; key_in = ka;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0; start = 1'b1; key_in = kb;
    tick();
    rst_n = 1'b1; start = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_kv", 128'(keys_valid), 128'd0);
    sweep("abort_slot", 1'b1);
    saw_done = 1'b0;
    repeat (15) begin tick(); if (done) saw_done = 1'b1; end
    chk("abort_no_done", 128'(saw_done), 128'd0);
    model(kb);
    run("post_abort", kb, lat, bcnt);
    chk("post_abort_latency", 128'(lat), 128'd10);
    sweep("post_abort_slot", 1'b0);

    // start held through the done cycle: immediate second expansion.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    model(ka);
    start = 1'b1; key_in = ka;
    tick();
    lat = 0;
    while (!done && lat < 30) begin tick(); lat++; end
    chk("b2b_first_latency", 128'(lat), 128'd10);
    chk("b2b_first_kv", 128'(keys_valid), 128'd1);
    rd_idx = 4'd10; #0.5;
    chk("b2b_first_slot10", rd_key, gold[10]);
    key_in = kb;
    tick();
    start = 1'b0;
    chk("b2b_busy", 128'(busy), 128'd1);
    chk("b2b_done", 128'(done), 128'd0);
    chk("b2b_kv", 128'(keys_valid), 128'd0);
    model(kb);
    lat = 0;
    while (!done && lat < 30) begin tick(); lat++; end
    chk("b2b_second_latency", 128'(lat), 128'd10);
    sweep("b2b_slot", 1'b0);

    // Random keys.
    for (int n = 0; n < 4; n++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      model(ka);
      run($sformatf("rnd%0d", n), ka, lat, bcnt);
      chk($sformatf("rnd%0d_latency", n), 128'(lat), 128'd10);
      sweep($sformatf("rnd%0d_slot", n), 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expand_seq.md
KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

Interface
REQ-001 Parameters: none; NUM_ROUNDS = 10 and the Rcon table are fixed package constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request expansion of key_in; sampled on the rising edge.
REQ-005 key_in  input  128 [0:127]  AES-128 cipher key, column-major, bit 0 = MSB of byte 0; captured only on an accepted start.
REQ-006 rd_idx  input  4  round-key select, 0..10.
REQ-007 rd_key  output  128 [0:127]  stored round key rd_idx, combinational read of the key store.
REQ-008 busy  output  1  high while expansion is in progress.
REQ-009 done  output  1  one-cycle pulse when round key 10 is stored.
REQ-010 keys_valid  output  1  high while all 11 stored keys belong to the last accepted key_in.

Function
REQ-011 FSM states: IDLE, EXPAND, DONE.
REQ-012 start is accepted in IDLE or DONE only; start in EXPAND is ignored and never restarts or corrupts the sequence.
REQ-013 Accepted start at edge E0: slot0 <= key_in, rnd <= 1, state <= EXPAND, keys_valid <= 0.
REQ-014 EXPAND: at each edge, slot[rnd] <= one-round key expansion of slot[rnd-1] using Rcon[rnd], then rnd <= rnd+1; exactly one round per cycle.
REQ-015 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex), placed in the most significant byte of a 32-bit word.
REQ-016 Round step: RotWord on word 3 (bytes 13,14,15,12), SubBytes via AES S-box, XOR Rcon, then w0' = t^w0, w1' = w0'^w1, w2' = w1'^w2, w3' = w2'^w3.
REQ-017 Edge E10 writes slot10, state <= DONE, keys_valid <= 1; done is high for exactly the cycle following E10.
REQ-018 DONE -> IDLE after one cycle unless start is accepted in that cycle; keys_valid remains 1 until the next accepted start.
REQ-019 Latency: start edge to done high = 10 cycles; back-to-back start in the done cycle is accepted.
REQ-020 busy = 1 in EXPAND only.
REQ-021 rd_key returns slot[rd_idx] in any state, including partially written slots during EXPAND; rd_idx 11..15 returns all zeros.
REQ-022 rnd range is 1..10; rnd is never 0 or >10 in EXPAND; no wrap-around.

Reset
REQ-023 rst_n low at a clock edge: state <= IDLE, rnd <= 0, busy = 0, done = 0, keys_valid = 0, all 11 slots <= 0.
REQ-024 Reset mid-EXPAND aborts immediately; no done pulse; a start sampled while rst_n is low is ignored.

Structure
REQ-025 Shared package aes_key_pkg holds NUM_ROUNDS, RCON table, the FSM state type, and the 128-bit key type.
REQ-026 Exactly one instance of the existing round_key sub-module is time-shared across all ten rounds; its rcon input is driven from RCON[rnd].
REQ-027 The key store is 11 x 128-bit registers; no other storage.

Verification
REQ-028 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> slot1 = a0fafe1788542cb123a339392a6c7605, slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done high exactly 10 cycles after the start edge.
REQ-029 Key 000102030405060708090a0b0c0d0e0f -> slot10 = 13111d7fe3944a17f307a78b4d2b30c5; busy high for 10 cycles, keys_valid 1 from the done cycle.
REQ-030 start re-asserted at cycle 4 of EXPAND with a different key_in -> ignored; results equal the first key's expansion.
REQ-031 rst_n low at cycle 5 of EXPAND -> no done, keys_valid 0, all slots read 0; a fresh start then completes normally.
REQ-032 start held high through the done cycle -> second expansion begins with no idle cycle; keys_valid drops to 0 on the following edge.
REQ-033 rd_idx sweep 0..15 after completion -> slots 0..10 match the golden model; indices 11..15 read 0.
